// File: rtl/usb_crc_rx_ctrl.sv
// Per-packet sequencer for the USB receive CRC5/CRC16 checker: PID decode, clear/enable, length and status.
// Define USB_CRC_RX_STATS_EN to add good/error packet counters (o_good_cnt, o_err_cnt) and i_stats_clr.
module usb_crc_rx_ctrl #(
    parameter int MAX_BYTES = 64,
    parameter int CHK_LAT   = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_pid_valid,
    input  logic [7:0]  i_pid,
    input  logic        i_bit_valid,
    input  logic        i_eop,
    input  logic        i_rx_abort,
    input  logic        i_crc_check,
`ifdef USB_CRC_RX_STATS_EN
    input  logic        i_stats_clr,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_err_cnt,
`endif
    output logic        o_crc_clear,
    output logic        o_crc_enable,
    output logic        o_packet_type,
    output logic        o_pkt_done,
    output logic [1:0]  o_pkt_kind,
    output logic        o_crc_err,
    output logic        o_len_err,
    output logic        o_pid_err,
    output logic        o_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TOKEN = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int MAX_BITS = MAX_BYTES * 8 + 16;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(CHK_LAT - 1);

    logic [2:0]    r_state;
    logic          r_clear;
    logic          r_enable;
    logic          r_ptype;
    logic [1:0]    r_kind;
    logic          r_crc_err;
    logic          r_len_err;
    logic          r_pid_err;
    logic [10:0]   r_bits;
    logic [TW-1:0] r_to;
    logic [LW-1:0] r_lat;

    logic          w_pid_ok;
    logic          w_is_token;
    logic          w_is_data;
    logic          w_is_hs;
    logic [10:0]   w_bits_next;
    logic          w_len_bad;
    logic          w_done;

    assign w_pid_ok = (i_pid[7:4] == ~i_pid[3:0]);

    always_comb begin
        w_is_token = 1'b0;
        w_is_data  = 1'b0;
        w_is_hs    = 1'b0;
        case (i_pid[3:0])
            4'b0001, 4'b1001, 4'b1101, 4'b0101: w_is_token = 1'b1;
            4'b0011, 4'b1011, 4'b0111, 4'b1111: w_is_data  = 1'b1;
            4'b0010, 4'b1010, 4'b1110, 4'b0110: w_is_hs    = 1'b1;
            default: ;
        endcase
    end

    // A bit arriving together with eop is counted before the length is judged.
    assign w_bits_next = (i_bit_valid && (r_bits != 11'h7FF)) ? r_bits + 11'd1 : r_bits;

    always_comb begin
        if (w_bits_next == 11'h7FF)
            w_len_bad = 1'b1;
        else if (r_state == S_TOKEN)
            w_len_bad = (w_bits_next != 11'd16);
        else
            w_len_bad = (w_bits_next < 11'd16) || (w_bits_next[2:0] != 3'd0) ||
                        (32'(w_bits_next) > MAX_BITS);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_clear   <= 1'b0;
            r_enable  <= 1'b0;
            r_ptype   <= 1'b0;
            r_kind    <= 2'b00;
            r_crc_err <= 1'b0;
            r_len_err <= 1'b0;
            r_pid_err <= 1'b0;
            r_bits    <= '0;
            r_to      <= '0;
            r_lat     <= '0;
        end else begin
            r_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_pid_valid) begin
                        r_crc_err <= 1'b0;
                        r_len_err <= 1'b0;
                        r_bits    <= '0;
                        r_to      <= '0;
                        if (w_pid_ok && (w_is_token || w_is_data)) begin
                            r_state   <= w_is_data ? S_DATA : S_TOKEN;
                            r_clear   <= 1'b1;
                            r_ptype   <= w_is_data;
                            r_kind    <= {1'b0, w_is_data};
                            r_pid_err <= 1'b0;
                        end else begin
                            r_state   <= S_DONE;
                            r_kind    <= (w_pid_ok && w_is_hs) ? 2'b10 : 2'b11;
                            r_pid_err <= !(w_pid_ok && w_is_hs);
                        end
                    end
                end
                S_TOKEN, S_DATA: begin
                    r_bits <= w_bits_next;
                    r_to   <= i_bit_valid ? '0 : r_to + 1'b1;
                    // Abort outranks eop, and eop outranks the inactivity timeout.
                    if (i_rx_abort) begin
                        r_state   <= S_DONE;
                        r_enable  <= 1'b0;
                        r_crc_err <= 1'b1;
                        r_len_err <= 1'b1;
                    end else if (i_eop) begin
                        r_state   <= S_WAIT;
                        r_enable  <= 1'b0;
                        r_len_err <= w_len_bad;
                        r_lat     <= LAT_LOAD;
                    end else if (!i_bit_valid && (r_to == TO_LAST)) begin
                        r_state   <= S_DONE;
                        r_enable  <= 1'b0;
                        r_len_err <= 1'b1;
                    end else begin
                        r_enable  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_rx_abort) begin
                        r_state   <= S_DONE;
                        r_crc_err <= 1'b1;
                        r_len_err <= 1'b1;
                    end else if (r_lat == '0) begin
                        r_state   <= S_DONE;
                        r_crc_err <= ~i_crc_check;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_kind    <= 2'b00;
                    r_crc_err <= 1'b0;
                    r_len_err <= 1'b0;
                    r_pid_err <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_done        = (r_state == S_DONE);
    assign o_crc_clear   = r_clear;
    assign o_crc_enable  = r_enable;
    assign o_packet_type = r_ptype;
    assign o_pkt_done    = w_done;
    assign o_pkt_kind    = w_done ? r_kind : 2'b00;
    assign o_crc_err     = w_done & r_crc_err;
    assign o_len_err     = w_done & r_len_err;
    assign o_pid_err     = w_done & r_pid_err;
    assign o_busy        = (r_state != S_IDLE);

`ifdef USB_CRC_RX_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_err_cnt;
    logic        w_any_err;

    assign w_any_err = r_crc_err | r_len_err | r_pid_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (i_stats_clr) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_done) begin
            if (!w_any_err && (r_good_cnt != 16'hFFFF))
                r_good_cnt <= r_good_cnt + 16'd1;
            else if (w_any_err && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign o_good_cnt = r_good_cnt;
    assign o_err_cnt  = r_err_cnt;
`endif

endmodule
